data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 31 +++
 rtl/data_mem_resp_dmem_array.sv | 37 +++
 rtl/data_mem_resp.sv | 176 +++++++++++++++++
 tb/tb_data_mem_resp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg
// Shared definitions for the data-memory response block: the data/address
// width macro `DATA_WID, the FSM state encoding, the default wait-state count
// and a small address helper.
// Ports: none (package).

`ifndef DATA_WID
`define DATA_WID 64
`endif

package data_mem_resp_pkg;

  // FSM state encoding shared by the block and anything that inspects it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Default number of wait states between accept and response.
  localparam int DEFAULT_WAIT_CYCLES = 2;

  // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15).
  localparam int WAIT_CNT_W = 4;

  // True when a byte address does not sit on a 64-bit word boundary.
  function automatic logic addr_misaligned(input logic [2:0] i_lo);
    return (i_lo != 3'd0);
  endfunction

endpackage

// File: rtl/data_mem_resp_dmem_array.sv
// dmem_array
// Word storage for data_mem_resp: one synchronous write port and one
// asynchronous read port. Contents are never cleared by reset.
// Ports:
//   clk      - clock, write happens on its rising edge
//   i_we     - write enable
//   i_widx   - write word index
//   i_wdata  - write data
//   i_ridx   - read word index
//   o_rdata  - word at i_ridx (combinational)

module dmem_array #(
  parameter int WORDS = 256,
  parameter int DW    = 64,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [DW-1:0]    i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [DW-1:0]    o_rdata
);

  logic [DW-1:0] r_mem [0:WORDS-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  // Asynchronous read port; the caller registers the result.
  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp
// Memory-stage data memory with a fixed response latency. A request is
// accepted in IDLE, waits WAIT_CYCLES cycles in BUSY, then produces a
// one-cycle response in RESP. Faults (out-of-range word, read+write together,
// and optionally a misaligned address) are reported through dmem_error and
// suppress the write / zero the read data.
// Build option: define DMEM_ALIGN_CHECK_EN to treat addr[2:0]!=0 as a fault;
// otherwise the low address bits are ignored and the containing word is used.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid, req_ready  - request handshake (ready only in IDLE)
//   req_read, req_write   - operation select
//   req_addr, req_wdata   - byte address and write data
//   rsp_valid             - one-cycle completion pulse
//   rsp_rdata, dmem_error - read data and fault flag, valid with rsp_valid

module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [`DATA_WID-1:0] req_addr,
  input  logic [`DATA_WID-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [`DATA_WID-1:0] rsp_rdata,
  output logic                 dmem_error
);

  localparam int DW    = `DATA_WID;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t                r_state;
  state_t                w_next;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_next;
  logic                  w_accept;

  logic [DW-1:0]         r_addr;
  logic [DW-1:0]         r_wdata;
  logic                  r_read;
  logic                  r_write;

  logic                  r_rsp_valid;
  logic [DW-1:0]         r_rdata;
  logic                  r_err;

  logic [DW-1:0]         w_src_addr;
  logic [DW-1:0]         w_src_wdata;
  logic                  w_src_read;
  logic                  w_src_write;
  logic [DW-4:0]         w_word;
  logic                  w_oor;
  logic                  w_mis;
  logic                  w_err;
  logic                  w_enter_resp;
  logic                  w_we;
  logic [IDX_W-1:0]      w_idx;
  logic [DW-1:0]         w_rd_data;

  // With zero wait states the response is produced on the accept edge itself,
  // before anything is latched, so the operands come straight from the ports
  // while in IDLE and from the latched copy otherwise.
  assign w_src_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_src_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_src_read  = (r_state == ST_IDLE) ? req_read  : r_read;
  assign w_src_write = (r_state == ST_IDLE) ? req_write : r_write;

  assign w_word = w_src_addr[DW-1:3];
  assign w_oor  = ({3'b000, w_word} >= DW'(MEM_WORDS));
  assign w_idx  = w_word[IDX_W-1:0];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis = addr_misaligned(w_src_addr[2:0]);
`else
  logic [2:0] w_unused_lo;
  assign w_unused_lo = w_src_addr[2:0];
  assign w_mis       = 1'b0;
`endif

  assign w_err        = w_oor | (w_src_read & w_src_write) | w_mis;
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
  // Reset on the same edge wins: an uncommitted write is dropped.
  assign w_we         = w_enter_resp & w_src_write & ~w_err & ~rst;

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign dmem_error = r_err;

  // Next-state and wait-counter logic.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && (req_read || req_write)) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next = ST_RESP;
          end else begin
            w_next     = ST_BUSY;
            w_cnt_next = WAIT_CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // State, counter, request latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_rsp_valid <= w_enter_resp;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_read  <= req_read;
        r_write <= req_write;
      end
      // Response data/error only change when entering RESP and hold otherwise.
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || !w_src_read) ? '0 : w_rd_data;
      end
    end
  end

  dmem_array #(
    .WORDS (MEM_WORDS),
    .DW    (DW),
    .IDX_W (IDX_W)
  ) u_dmem_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wdata (w_src_wdata),
    .i_ridx  (w_idx),
    .o_rdata (w_rd_data)
  );

endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp
// Self-checking bench for data_mem_resp: directed scenarios plus randomized
// traffic against a word-array reference model. A second instance with zero
// wait states covers back-to-back behaviour.

module tb_data_mem_resp;

  localparam int WAIT2 = 2;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_read, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, dmem_error;
  logic [63:0] rsp_rdata;

  logic        b_valid, b_ready, b_read, b_write;
  logic [63:0] b_addr, b_wdata;
  logic        b_rsp_valid, b_err;
  logic [63:0] b_rdata;

  logic [63:0] mem_m [0:255];
  int          n_checks;
  int          n_pass;

  data_mem_resp #(.MEM_WORDS(256), .WAIT_CYCLES(WAIT2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .dmem_error(dmem_error)
  );

  data_mem_resp #(.MEM_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_read(b_read), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .dmem_error(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected fault for an access, from the addressing rules.
  function automatic logic model_err(input logic rd, input logic wr, input logic [63:0] addr);
    logic e;
    e = (addr[63:3] >= 61'd256) || (rd && wr);
`ifdef DMEM_ALIGN_CHECK_EN
    if (addr[2:0] != 3'd0) e = 1'b1;
`endif
    return e;
  endfunction

  // One full transaction on the WAIT_CYCLES=2 instance; entered and left
  // #1 after a rising edge with the DUT idle.
  task automatic do_req(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, input logic chk_all);
    logic        exp_err;
    logic [63:0] exp_rd;
    logic [7:0]  idx;
    int          n;
    exp_err = model_err(rd, wr, addr);
    idx     = addr[10:3];
    exp_rd  = (!exp_err && rd) ? mem_m[idx] : 64'd0;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr  = addr; req_wdata = wd;
    if (chk_all) check_eq("ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    n = 1;
    // Junk on the request bus while the request is in flight must be ignored.
    req_read = 1'($urandom); req_write = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    check_eq("latency", 64'(n), 64'(WAIT2 + 1));
    check_eq("err", {63'd0, dmem_error}, {63'd0, exp_err});
    if (rd || exp_err) check_eq("rdata", rsp_rdata, exp_rd);
    if (wr && !exp_err) mem_m[idx] = wd;
    @(posedge clk); #1;
    if (chk_all) begin
      check_eq("pulse_one", {63'd0, rsp_valid}, 64'd0);
      check_eq("err_hold", {63'd0, dmem_error}, {63'd0, exp_err});
      if (rd || exp_err) check_eq("rdata_hold", rsp_rdata, exp_rd);
    end
  endtask

  // A valid request with no operation selected must be ignored.
  task automatic do_noop(input logic [63:0] addr);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = addr;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("noop_rsp", {63'd0, rsp_valid}, 64'd0);
      check_eq("noop_ready", {63'd0, req_ready}, 64'd1);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int p_first, p_second, p_cnt;
    n_checks = 0; n_pass = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 64'd0;
    rst = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    b_valid = 1'b0; b_read = 1'b0; b_write = 1'b0; b_addr = 64'd0; b_wdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_rdata", rsp_rdata, 64'd0);
    check_eq("rst_err", {63'd0, dmem_error}, 64'd0);
    rst = 1'b0;

    // Establish known contents (all zero) through the write path.
    for (int i = 0; i < 256; i++) do_req(1'b0, 1'b1, 64'(i * 8), 64'd0, 1'b0);

    // Write then read back a word.
    do_req(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 1'b1);
    do_req(1'b1, 1'b0, 64'h10, 64'd0, 1'b1);
    // Out-of-range read, then the last word is unchanged.
    do_req(1'b0, 1'b1, 64'h7F8, 64'hCAFEF00DDEADBEEF, 1'b1);
    do_req(1'b1, 1'b0, 64'h800, 64'd0, 1'b1);
    do_req(1'b1, 1'b0, 64'h7F8, 64'd0, 1'b1);
    // Read and write together is a fault and must not write.
    do_req(1'b1, 1'b1, 64'h20, 64'hFF, 1'b1);
    do_req(1'b1, 1'b0, 64'h20, 64'd0, 1'b1);
    // Misaligned write: fault with alignment checking, containing word otherwise.
    do_req(1'b0, 1'b1, 64'h13, 64'hAB, 1'b1);
    do_req(1'b1, 1'b0, 64'h10, 64'd0, 1'b1);

    // Reset while a write to 0x30 is waiting.
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_addr = 64'h30; req_wdata = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_ready", {63'd0, req_ready}, 64'd1);
    check_eq("abort_rsp", {63'd0, rsp_valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_eq("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    do_req(1'b1, 1'b0, 64'h30, 64'd0, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      int          o, k;
      logic [63:0] a;
      k = $urandom_range(0, 9);
      if (k == 0)      a = {$urandom, $urandom};
      else if (k == 1) a = 64'h800 + 64'($urandom_range(0, 64));
      else             a = 64'($urandom_range(0, 255) * 8) + ((k == 2) ? 64'($urandom_range(0, 7)) : 64'd0);
      o = $urandom_range(0, 19);
      if (o == 0)      do_noop(a);
      else if (o == 1) do_req(1'b1, 1'b1, a, {$urandom, $urandom}, 1'b1);
      else if (o < 11) do_req(1'b1, 1'b0, a, 64'd0, 1'b1);
      else             do_req(1'b0, 1'b1, a, {$urandom, $urandom}, 1'b1);
    end

    // Zero-wait instance: write, then back-to-back reads with valid held.
    b_valid = 1'b1; b_write = 1'b1; b_read = 1'b0; b_addr = 64'h40; b_wdata = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check_eq("w0_latency", {63'd0, b_rsp_valid}, 64'd1);
    check_eq("w0_ready_resp", {63'd0, b_ready}, 64'd0);
    check_eq("w0_err", {63'd0, b_err}, 64'd0);
    @(posedge clk); #1;
    b_valid = 1'b1; b_write = 1'b0; b_read = 1'b1;
    p_first = -1; p_second = -1; p_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (b_rsp_valid) begin
        p_cnt++;
        if (p_first < 0) p_first = c; else if (p_second < 0) p_second = c;
        check_eq("w0_ready_resp", {63'd0, b_ready}, 64'd0);
        check_eq("w0_rdata", b_rdata, 64'h0123456789ABCDEF);
      end
    end
    b_valid = 1'b0;
    check_eq("w0_pulses", 64'(p_cnt), 64'd2);
    check_eq("w0_spacing", 64'(p_second - p_first), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
